// File: rtl/histo_pkg.sv
// Shared definitions for the histogram sequencer: defaults, FSM encodings, saturating increment.
package histo_pkg;

    localparam int unsigned PIX_W_DEF   = 8;
    localparam int unsigned CNT_W_DEF   = 24;
    localparam int unsigned NUM_PIX_DEF = 76800;
    localparam int unsigned BINS        = 2 ** PIX_W_DEF;
    localparam int unsigned OUT_W       = PIX_W_DEF + CNT_W_DEF;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_ACCUM = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Increment a w-bit counter (w <= 32) held in a 32-bit container, sticking at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
        logic [31:0] max_val;
        max_val = 32'hFFFF_FFFF >> (32 - w);
        sat_inc = (val == max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/histo_rmw_pipe.sv
// Two-stage read-modify-write for bin counts with a one-deep write forward.
module histo_rmw_pipe
    import histo_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_addr,
    input  logic [CNT_W-1:0] rdata,
    output logic             we_c,
    output logic [PIX_W-1:0] waddr_c,
    output logic [CNT_W-1:0] wdata_c
);

    logic             s2_valid;
    logic [PIX_W-1:0] s2_addr;
    logic             prev_we;
    logic [PIX_W-1:0] prev_addr;
    logic [CNT_W-1:0] prev_data;
    logic [CNT_W-1:0] base;

    // S1 -> S2 capture plus the previous write kept for forwarding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_addr   <= '0;
            prev_we   <= 1'b0;
            prev_addr <= '0;
            prev_data <= '0;
        end else begin
            s2_valid  <= in_valid;
            s2_addr   <= in_addr;
            prev_we   <= s2_valid;
            prev_addr <= s2_addr;
            prev_data <= wdata_c;
        end
    end

    // RAM returned pre-write data if the last cycle wrote this bin: use the written value instead
    always_comb begin
        base    = (prev_we && (prev_addr == s2_addr)) ? prev_data : rdata;
        wdata_c = CNT_W'(sat_inc(32'(base), CNT_W));
    end

    assign we_c    = s2_valid;
    assign waddr_c = s2_addr;

endmodule

// File: rtl/histogram_ctrl.sv
// Histogram sequencer: clear bins, accumulate a pixel stream, then stream out {bin, count}.
module histogram_ctrl
    import histo_pkg::*;
#(
    parameter int unsigned PIX_W   = PIX_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned NUM_PIX = NUM_PIX_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    input  logic                   pix_valid_i,
    input  logic [PIX_W-1:0]       pix_data_i,
    output logic                   pix_ready_o,
    output logic                   ram_re_o,
    output logic [PIX_W-1:0]       ram_raddr_o,
    input  logic [CNT_W-1:0]       ram_rdata_i,
    output logic                   ram_we_o,
    output logic [PIX_W-1:0]       ram_waddr_o,
    output logic [CNT_W-1:0]       ram_wdata_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [PIX_W+CNT_W-1:0] out_data_o,
    output logic                   out_last_o
);

    localparam int unsigned       N_BINS   = 2 ** PIX_W;
    localparam int unsigned       PCNT_W   = $clog2(NUM_PIX + 1);
    localparam logic [PIX_W-1:0]  LAST_BIN = PIX_W'(N_BINS - 1);
    localparam logic [PCNT_W-1:0] LAST_PIX = PCNT_W'(NUM_PIX - 1);
    localparam logic [PCNT_W-1:0] PIX_MAX  = PCNT_W'(NUM_PIX);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [PIX_W-1:0]  bin_idx;
    logic [PIX_W-1:0]  rd_idx;
    logic [PCNT_W-1:0] pix_cnt;
    logic              rd_first;
    logic              rd_pend;
    logic              accept;
    logic              issue;
    logic              beat_done;
    logic              pipe_we;
    logic [PIX_W-1:0]  pipe_waddr;
    logic [CNT_W-1:0]  pipe_wdata;

    assign beat_done = out_valid_o && out_ready_i;

    histo_rmw_pipe #(
        .PIX_W (PIX_W),
        .CNT_W (CNT_W)
    ) u_rmw (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .in_valid (accept),
        .in_addr  (pix_data_i),
        .rdata    (ram_rdata_i),
        .we_c     (pipe_we),
        .waddr_c  (pipe_waddr),
        .wdata_c  (pipe_wdata)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-phase RAM/handshake decode
    always_comb begin
        state_nxt   = state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        pix_ready_o = 1'b0;
        accept      = 1'b0;
        issue       = 1'b0;
        ram_re_o    = 1'b0;
        ram_raddr_o = '0;
        ram_we_o    = 1'b0;
        ram_waddr_o = '0;
        ram_wdata_o = '0;
        case (state)
            ST_IDLE: begin
                if (start_i) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                busy_o      = 1'b1;
                ram_we_o    = 1'b1;
                ram_waddr_o = bin_idx;
                if (bin_idx == LAST_BIN) state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                busy_o      = 1'b1;
                pix_ready_o = (pix_cnt < PIX_MAX);
                accept      = pix_valid_i && pix_ready_o;
                ram_re_o    = accept;
                ram_raddr_o = pix_data_i;
                ram_we_o    = pipe_we;
                ram_waddr_o = pipe_waddr;
                ram_wdata_o = pipe_wdata;
                if (accept && (pix_cnt == LAST_PIX)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy_o      = 1'b1;
                ram_we_o    = pipe_we;
                ram_waddr_o = pipe_waddr;
                ram_wdata_o = pipe_wdata;
                state_nxt   = ST_READ;
            end
            ST_READ: begin
                busy_o      = 1'b1;
                issue       = rd_first || (beat_done && !out_last_o);
                ram_re_o    = issue;
                ram_raddr_o = bin_idx;
                if (beat_done && out_last_o) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done_o    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bin and pixel counters, readout issue tracking and the output beat register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_idx     <= '0;
            pix_cnt     <= '0;
            rd_idx      <= '0;
            rd_first    <= 1'b0;
            rd_pend     <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
        end else begin
            rd_first <= (state == ST_DRAIN);
            rd_pend  <= issue;
            if ((state == ST_IDLE) && start_i) begin
                bin_idx <= '0;
                pix_cnt <= '0;
            end
            if (state == ST_CLEAR) bin_idx <= bin_idx + PIX_W'(1);
            if (state == ST_DRAIN) bin_idx <= '0;
            if (accept) pix_cnt <= pix_cnt + PCNT_W'(1);
            if (issue) begin
                rd_idx  <= bin_idx;
                bin_idx <= bin_idx + PIX_W'(1);
            end
            if (rd_pend) begin
                out_valid_o <= 1'b1;
                out_data_o  <= {rd_idx, ram_rdata_i};
                out_last_o  <= (rd_idx == LAST_BIN);
            end else if (beat_done) begin
                out_valid_o <= 1'b0;
                out_last_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_histogram_ctrl.sv
// Bench for histogram_ctrl: RAM models, pixel drivers and a readout scoreboard.
`timescale 1ns/1ps
module tb_histogram_ctrl;
    import histo_pkg::*;

    localparam int unsigned NP   = 16;
    localparam int unsigned S_CW = 4;
    localparam int unsigned S_NP = 20;
    localparam int unsigned S_OW = PIX_W_DEF + S_CW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic                 start     = 1'b0;
    logic                 pix_valid = 1'b0;
    logic [PIX_W_DEF-1:0] pix_data  = '0;
    logic                 out_ready = 1'b1;
    logic                 busy, done, pix_ready, ram_re, ram_we, out_valid, out_last;
    logic [PIX_W_DEF-1:0] ram_raddr, ram_waddr;
    logic [CNT_W_DEF-1:0] ram_rdata, ram_wdata;
    logic [OUT_W-1:0]     out_data;

    // saturation instance signals
    logic                 s_start     = 1'b0;
    logic                 s_pix_valid = 1'b0;
    logic [PIX_W_DEF-1:0] s_pix_data  = '0;
    logic                 s_out_ready = 1'b1;
    logic                 s_busy, s_done, s_pix_ready, s_ram_re, s_ram_we, s_out_valid, s_out_last;
    logic [PIX_W_DEF-1:0] s_ram_raddr, s_ram_waddr;
    logic [S_CW-1:0]      s_ram_rdata, s_ram_wdata;
    logic [S_OW-1:0]      s_out_data;

    histogram_ctrl #(.PIX_W(PIX_W_DEF), .CNT_W(CNT_W_DEF), .NUM_PIX(NP)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
        .pix_valid_i(pix_valid), .pix_data_i(pix_data), .pix_ready_o(pix_ready),
        .ram_re_o(ram_re), .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata),
        .ram_we_o(ram_we), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_last_o(out_last)
    );

    histogram_ctrl #(.PIX_W(PIX_W_DEF), .CNT_W(S_CW), .NUM_PIX(S_NP)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .busy_o(s_busy), .done_o(s_done),
        .pix_valid_i(s_pix_valid), .pix_data_i(s_pix_data), .pix_ready_o(s_pix_ready),
        .ram_re_o(s_ram_re), .ram_raddr_o(s_ram_raddr), .ram_rdata_i(s_ram_rdata),
        .ram_we_o(s_ram_we), .ram_waddr_o(s_ram_waddr), .ram_wdata_o(s_ram_wdata),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .out_data_o(s_out_data),
        .out_last_o(s_out_last)
    );

    // 1-cycle simple-dual-port RAMs, read-during-write returns old data, not reset
    logic [CNT_W_DEF-1:0] mem   [BINS];
    logic [S_CW-1:0]      s_mem [BINS];
    always @(posedge clk) begin
        if (ram_re) ram_rdata <= mem[ram_raddr];
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (s_ram_re) s_ram_rdata <= s_mem[s_ram_raddr];
        if (s_ram_we) s_mem[s_ram_waddr] <= s_ram_wdata;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned inc_sat(input int unsigned v, input int unsigned w);
        int unsigned m;
        m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= m) ? m : v + 1;
    endfunction

    // scoreboards: {last, bin, count}
    logic [OUT_W:0] exp_q [$];
    logic [S_OW:0]  s_exp_q [$];
    int unsigned    hist [BINS];
    int unsigned    s_hist [BINS];

    // random readout backpressure for the main instance
    bit bp_en = 1'b0;
    always @(posedge clk) #1 out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;

    // main readout monitor: ordering, hold-while-stalled, done pulses
    int               beats      = 0;
    int               done_cnt   = 0;
    bit               stall_q    = 1'b0;
    logic [OUT_W-1:0] stall_data = '0;
    logic [OUT_W:0]   e_main;
    always @(negedge clk) begin
        if (stall_q) check("hold", 64'({out_valid, out_data}), 64'({1'b1, stall_data}));
        if (out_valid && out_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
                check("extra_beat", 64'(exp_q.size()), 64'd1);
            end else begin
                e_main = exp_q.pop_front();
                check("beat", 64'({out_last, out_data}), 64'(e_main));
            end
        end
        if (done) done_cnt++;
        stall_q    = out_valid && !out_ready;
        stall_data = out_data;
    end

    // saturation readout monitor
    int            s_beats    = 0;
    int            s_done_cnt = 0;
    logic [S_OW:0] e_sat;
    always @(negedge clk) begin
        if (s_out_valid && s_out_ready) begin
            s_beats++;
            if (s_exp_q.size() == 0) begin
                check("s_extra_beat", 64'(s_exp_q.size()), 64'd1);
            end else begin
                e_sat = s_exp_q.pop_front();
                check("s_beat", 64'({s_out_last, s_out_data}), 64'(e_sat));
            end
        end
        if (s_done) s_done_cnt++;
    end

    task automatic send_pix(input logic [PIX_W_DEF-1:0] p, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b1;
        pix_data  = p;
        t = 0;
        @(negedge clk);
        while (!pix_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!pix_ready) check("pix_ready_tmo", 64'(pix_ready), 64'd1);
        @(posedge clk);
        #1 pix_valid = 1'b0;
    endtask

    task automatic run_main(input logic [PIX_W_DEF-1:0] pix [$], input int gaps [$], input bit poke);
        int t;
        for (int b = 0; b < BINS; b++) hist[b] = 0;
        beats    = 0;
        done_cnt = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_on_start", 64'(busy), 64'd1);
        if (poke) begin
            repeat (20) @(posedge clk);
            #1 check("in_clear", 64'(ram_we), 64'd1);
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int i = 0; i < pix.size(); i++) begin
            send_pix(pix[i], gaps[i]);
            hist[pix[i]] = inc_sat(hist[pix[i]], CNT_W_DEF);
        end
        for (int b = 0; b < BINS; b++)
            exp_q.push_back({(b == BINS - 1), PIX_W_DEF'(b), CNT_W_DEF'(hist[b])});
        if (poke) begin
            t = 0;
            while (!out_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("read_reached", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        t = 0;
        @(negedge clk);
        while (!done && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", 64'(done), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        check("beat_count", 64'(beats), 64'(BINS));
        check("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_sat();
        int n;
        int t;
        for (int b = 0; b < BINS; b++) s_hist[b] = 0;
        s_beats    = 0;
        s_done_cnt = 0;
        @(posedge clk);
        #1 s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        s_pix_valid = 1'b1;
        s_pix_data  = 8'hFF;
        n = 0;
        t = 0;
        while (n < int'(S_NP) && t < 1000) begin
            @(negedge clk);
            if (s_pix_ready) begin
                n++;
                s_hist[255] = inc_sat(s_hist[255], S_CW);
            end
            t++;
        end
        @(posedge clk);
        #1 s_pix_valid = 1'b0;
        check("s_pix_sent", 64'(n), 64'(S_NP));
        for (int b = 0; b < BINS; b++)
            s_exp_q.push_back({(b == BINS - 1), PIX_W_DEF'(b), S_CW'(s_hist[b])});
        t = 0;
        @(negedge clk);
        while (!s_done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("s_done_seen", 64'(s_done), 64'd1);
        repeat (3) @(negedge clk);
        check("s_done_pulses", 64'(s_done_cnt), 64'd1);
        check("s_beat_count", 64'(s_beats), 64'(BINS));
        check("s_sb_empty", 64'(s_exp_q.size()), 64'd0);
    endtask

    logic [PIX_W_DEF-1:0] pix_q [$];
    int                   gap_q [$];
    logic [PIX_W_DEF-1:0] t3_pix [6];
    int                   t3_gap [6];

    initial begin
        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 64'({busy, done, pix_ready, ram_re, ram_we, out_valid, out_last}), 64'd0);
        check("rst_ram", 64'({ram_raddr, ram_waddr, ram_wdata}), 64'd0);
        check("rst_out", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("idle_ctrl", 64'({busy, done, pix_ready, out_valid}), 64'd0);

        // run aborted by reset in the middle of accumulation
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 8; i++) send_pix(8'h09, 0);
        pix_valid = 1'b1;
        pix_data  = 8'h09;
        @(negedge clk);
        check("mid_accum", 64'(pix_ready), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ctrl", 64'({busy, done, pix_ready, ram_re, ram_we, out_valid, out_last}), 64'd0);
        check("abort_ram", 64'({ram_raddr, ram_waddr, ram_wdata}), 64'd0);
        pix_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // restart: 16 back-to-back pixels of 0x05
        pix_q = {};
        gap_q = {};
        for (int i = 0; i < int'(NP); i++) begin
            pix_q.push_back(8'h05);
            gap_q.push_back(0);
        end
        run_main(pix_q, gap_q, 1'b0);

        // gapped pixels, backpressure, ignored start pulses in CLEAR and READ
        t3_pix = '{8'd3, 8'd3, 8'd7, 8'd3, 8'd7, 8'd7};
        t3_gap = '{0, 2, 1, 0, 2, 1};
        pix_q = {};
        gap_q = {};
        for (int i = 0; i < 6; i++) begin
            pix_q.push_back(t3_pix[i]);
            gap_q.push_back(t3_gap[i]);
        end
        for (int i = 6; i < int'(NP); i++) begin
            pix_q.push_back(8'h00);
            gap_q.push_back(i % 3);
        end
        bp_en = 1'b1;
        run_main(pix_q, gap_q, 1'b1);
        bp_en = 1'b0;

        // saturation with a 4-bit counter
        run_sat();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
